retire_monitor: RTL
===================

# retire_monitor

Passive observer on the non-forwarding core's retire port (`o_pc_debug`/`o_insn_vld`), instantiated beside the scoreboard in the top-level bench.
- Keeps a circular trace of the last `DEPTH` retired PCs.
- Detects program end as a self-loop: the same PC retired `HALT_REPEAT` times in a row.
- Raises a watchdog flag when nothing retires for `TIMEOUT` cycles.
- Optionally keeps cycle and retire counters for CPI measurement.

## Interface
Parameters:
- `DEPTH`, 16: trace entries; power of two, ≥2.
- `TIMEOUT`, 1024: consecutive idle (no-retire) cycles before the watchdog fires; ≥2.
- `HALT_REPEAT`, 4: consecutive retires of an identical PC that count as a halt; ≥2.

Ports:
- `i_clk`  in  1: clock, rising edge.
- `i_reset`  in  1: asynchronous, active-high reset.
- `i_pc_debug`  in  32: PC of the retiring instruction.
- `i_insn_vld`  in  1: a retire occurs this cycle.
- `i_clear`  in  1: synchronous clear; same effect as reset.
- `i_rd_idx`  in  $clog2(DEPTH): trace read index; 0 is the most recent retire.
- `o_rd_pc`  out  32: registered trace readback.
- `o_trace_cnt`  out  $clog2(DEPTH)+1: number of valid entries, saturating at `DEPTH`.
- `o_halt`  out  1: self-loop detected.
- `o_halt_pc`  out  32: the looping PC.
- `o_timeout`  out  1: watchdog fired.
- `o_cycle_cnt`  out  32: cycles spent in RUN (stats).
- `o_retire_cnt`  out  32: retires accepted in RUN (stats).

## Operation
- FSM states: RUN, HALTED, TIMEDOUT. Reset and `i_clear` both go to RUN.
- RUN, retire (`i_insn_vld`=1):
  - Write the PC at the write pointer, then increment the pointer modulo `DEPTH` (wraps, overwriting the oldest entry).
  - `o_trace_cnt` increments, saturating at `DEPTH`.
  - Clear the idle counter.
  - Repeat counter: if PC equals the last retired PC, increment it; otherwise set it to 1. The first retire after reset sets it to 1.
  - If the PC equals the last retired PC and the repeat counter already equals `HALT_REPEAT`-1: go to HALTED, latch `o_halt_pc`. The PC is still written to the trace.
- RUN, no retire:
  - Idle counter increments.
  - If the idle counter equals `TIMEOUT`-1: go to TIMEDOUT.
- HALTED and TIMEDOUT are terminal until reset or `i_clear`:
  - Trace, pointer, counters and flags are frozen.
  - `i_insn_vld` is ignored.
- Halt and timeout cannot coincide: timeout requires no retire.
- `i_clear` together with `i_insn_vld`: the clear wins and the retire is dropped.
- Readback:
  - `o_rd_pc` <= trace[(wr_ptr-1-`i_rd_idx`) mod `DEPTH`] when `i_rd_idx` < `o_trace_cnt`, else 0.
  - The flopped value reflects trace contents before any write on the same edge.
- Stats (when compiled in):
  - `o_cycle_cnt` increments every RUN cycle.
  - `o_retire_cnt` increments on every accepted retire.
  - Both saturate at 32'hFFFF_FFFF and freeze outside RUN.

## Timing
- Reset values: all outputs 0, trace memory cleared to 0, pointer 0, state RUN.
- Reset is asynchronous assert; all other state changes happen on the rising edge of `i_clk`.
- A retire sampled at edge k is visible in `o_trace_cnt` and readable via `o_rd_pc` after edge k+1 (1-cycle read latency).
- `o_halt` and `o_halt_pc` are valid after the edge that samples the `HALT_REPEAT`-th identical retire.
- `o_timeout` rises after the edge that samples the `TIMEOUT`-th consecutive idle cycle.
- `i_clear` takes effect at the sampling edge; outputs are 0 from the next cycle.
- Reset mid-run discards all state; there is no partial-trace retention.

## Configuration
- Macro `RETIRE_MON_STATS_EN`.
- Defined: the cycle and retire counters are implemented and drive `o_cycle_cnt` and `o_retire_cnt`.
- Undefined: both counters are removed and the ports are tied to 32'h0. The trace, halt and watchdog logic are unchanged.

## Test plan
- Reset, then retire PCs 0x00,0x04,0x08 on consecutive cycles -> `o_trace_cnt`=3; `i_rd_idx`=0/1/2 give 0x08/0x04/0x00; `i_rd_idx`=3 gives 0.
- Retire 20 distinct PCs 0x00..0x4C step 4 (`DEPTH`=16) -> `o_trace_cnt`=16; idx 0 = 0x4C, idx 15 = 0x10 (wrap-around).
- Retire 0x40 four times back-to-back -> `o_halt`=1 and `o_halt_pc`=0x40 one cycle after the 4th retire; further retires don't change the trace.
- Same PC three times, a different PC, then the same PC twice more -> no halt (repeat counter restarts).
- Retire one PC, then hold `i_insn_vld`=0 for 1023 cycles -> `o_timeout`=0; on the 1024th idle cycle -> `o_timeout`=1.
- With `RETIRE_MON_STATS_EN`: 10 RUN cycles with 6 retires -> `o_cycle_cnt`=10, `o_retire_cnt`=6. Then `i_clear` asserted with `i_insn_vld`=1 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/retire_monitor.sv
// Passive retire-port observer: circular PC trace, self-loop halt detection and idle watchdog.
// Optional CPI counters are compiled in with `define RETIRE_MON_STATS_EN.
module retire_monitor #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned TIMEOUT     = 1024,
  parameter int unsigned HALT_REPEAT = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [31:0]                i_pc_debug,
  input  logic                       i_insn_vld,
  input  logic                       i_clear,
  input  logic [$clog2(DEPTH)-1:0]   i_rd_idx,
  output logic [31:0]                o_rd_pc,
  output logic [$clog2(DEPTH):0]     o_trace_cnt,
  output logic                       o_halt,
  output logic [31:0]                o_halt_pc,
  output logic                       o_timeout,
  output logic [31:0]                o_cycle_cnt,
  output logic [31:0]                o_retire_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned IW = $clog2(TIMEOUT) + 1;
  localparam int unsigned RW = $clog2(HALT_REPEAT) + 1;

  typedef enum logic [1:0] {RUN, HALTED, TIMEDOUT} state_t;

  state_t          state_q, state_d;
  logic [31:0]     trace [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_addr;
  logic [AW:0]     trace_cnt;
  logic [IW-1:0]   idle_cnt;
  logic [RW-1:0]   rep_cnt;
  logic [31:0]     last_pc;
  logic [31:0]     halt_pc;
  logic [31:0]     rd_pc;
  logic            retire;
  logic            same_pc;
  logic            halt_hit;
  logic            idle_hit;

  // last_pc is only meaningful once something has retired, hence the trace_cnt guard
  always_comb begin
    retire   = 1'b0;
    same_pc  = 1'b0;
    halt_hit = 1'b0;
    idle_hit = 1'b0;
    state_d  = state_q;
    if (state_q == RUN) begin
      retire   = i_insn_vld;
      same_pc  = (trace_cnt != '0) && (i_pc_debug == last_pc);
      halt_hit = retire && same_pc && (rep_cnt == RW'(HALT_REPEAT - 1));
      idle_hit = !i_insn_vld && (idle_cnt == IW'(TIMEOUT - 1));
    end
    if (i_clear)       state_d = RUN;
    else if (halt_hit) state_d = HALTED;
    else if (idle_hit) state_d = TIMEDOUT;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= RUN;
    else         state_q <= state_d;
  end

  assign rd_addr = wr_ptr - i_rd_idx - AW'(1);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) trace[i] <= '0;
    end else if (i_clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) trace[i] <= '0;
    end else if (retire) begin
      trace[wr_ptr] <= i_pc_debug;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr    <= '0;
      trace_cnt <= '0;
      idle_cnt  <= '0;
      rep_cnt   <= '0;
      last_pc   <= '0;
      halt_pc   <= '0;
      rd_pc     <= '0;
    end else if (i_clear) begin
      wr_ptr    <= '0;
      trace_cnt <= '0;
      idle_cnt  <= '0;
      rep_cnt   <= '0;
      last_pc   <= '0;
      halt_pc   <= '0;
      rd_pc     <= '0;
    end else begin
      // Readback samples the trace before this edge's write lands
      rd_pc <= ({1'b0, i_rd_idx} < trace_cnt) ? trace[rd_addr] : '0;
      if (retire) begin
        wr_ptr   <= wr_ptr + AW'(1);
        idle_cnt <= '0;
        last_pc  <= i_pc_debug;
        rep_cnt  <= same_pc ? rep_cnt + RW'(1) : RW'(1);
        if (trace_cnt != (AW+1)'(DEPTH)) trace_cnt <= trace_cnt + (AW+1)'(1);
        if (halt_hit) halt_pc <= i_pc_debug;
      end else if (state_q == RUN) begin
        idle_cnt <= idle_cnt + IW'(1);
      end
    end
  end

  assign o_rd_pc     = rd_pc;
  assign o_trace_cnt = trace_cnt;
  assign o_halt      = (state_q == HALTED);
  assign o_halt_pc   = halt_pc;
  assign o_timeout   = (state_q == TIMEDOUT);

`ifdef RETIRE_MON_STATS_EN
  logic [31:0] cycle_cnt;
  logic [31:0] retire_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
    end else if (i_clear) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
    end else if (state_q == RUN) begin
      if (cycle_cnt != '1)            cycle_cnt  <= cycle_cnt + 32'd1;
      if (retire && retire_cnt != '1) retire_cnt <= retire_cnt + 32'd1;
    end
  end

  assign o_cycle_cnt  = cycle_cnt;
  assign o_retire_cnt = retire_cnt;
`else
  assign o_cycle_cnt  = '0;
  assign o_retire_cnt = '0;
`endif

endmodule
